// File: rtl/bus_mem_responder.sv
// ============================================================================
// Module      : bus_mem_responder
// Description : Single-outstanding memory responder for the ibus and dbus,
//               backed by a 64-bit SRAM model. Optional macro
//               BUS_RESP_RANDOM_DELAY_EN adds 0..3 LFSR-driven wait cycles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_mem_responder #(
    parameter int          MEM_WORDS = 8192,
    parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
    parameter int          LATENCY   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ireq_valid,
    input  logic [63:0] ireq_addr,
    output logic        iresp_addr_ok,
    output logic        iresp_data_ok,
    output logic [31:0] iresp_data,
    input  logic        dreq_valid,
    input  logic [63:0] dreq_addr,
    input  logic [2:0]  dreq_size,
    input  logic [7:0]  dreq_strobe,
    input  logic [63:0] dreq_data,
    output logic        dresp_addr_ok,
    output logic        dresp_data_ok,
    output logic [63:0] dresp_data
);

    localparam int         c_IDX_W    = $clog2(MEM_WORDS);
    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_WAIT     = 2'd1;
    localparam logic [1:0] c_RESP     = 2'd2;
    localparam logic [4:0] c_CNT_INIT = 5'(LATENCY - 1);

    logic [1:0]         r_state;
    logic [1:0]         w_next;
    logic [4:0]         r_cnt;
    logic [4:0]         w_cnt_load;
    logic               w_accept;
    logic               w_accept_d;
    logic               w_fire;
    logic [63:0]        w_addr;
    logic [63:0]        w_off;
    logic               w_in_range;
    logic [63:0]        w_word;
    logic               w_unused;

    logic               r_sel_d;
    logic               r_hi;
    logic               r_inr;
    logic [c_IDX_W-1:0] r_idx;
    logic [7:0]         r_strobe;
    logic [63:0]        r_wdata;

    logic               r_iaddr_ok;
    logic               r_idata_ok;
    logic [31:0]        r_irdata;
    logic               r_daddr_ok;
    logic               r_ddata_ok;
    logic [63:0]        r_drdata;

    logic [63:0]        r_mem [MEM_WORDS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= c_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:  if (dreq_valid || ireq_valid) w_next = c_WAIT;
            c_WAIT:  if (r_cnt == 5'd0) w_next = c_RESP;
            c_RESP:  w_next = c_IDLE;
            default: w_next = c_IDLE;
        endcase
    end

    // The access itself happens on the WAIT->RESP edge, so RESP is the data_ok cycle.
    always_comb begin
        w_accept   = (r_state == c_IDLE) && (dreq_valid || ireq_valid);
        w_accept_d = (r_state == c_IDLE) && dreq_valid;
        w_fire     = (r_state == c_WAIT) && (r_cnt == 5'd0);
    end

    assign w_addr     = dreq_valid ? dreq_addr : ireq_addr;
    assign w_off      = w_addr - BASE_ADDR;
    assign w_in_range = (w_addr >= BASE_ADDR) && (w_off[63:c_IDX_W+3] == '0);
    assign w_unused   = ^{dreq_size, w_off[2:0]};

`ifdef BUS_RESP_RANDOM_DELAY_EN
    logic [15:0] r_lfsr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_lfsr <= 16'hACE1;
        else     r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end

    assign w_cnt_load = c_CNT_INIT + {3'b000, r_lfsr[1:0]};
`else
    assign w_cnt_load = c_CNT_INIT;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                  r_cnt <= 5'd0;
        else if (w_accept)                        r_cnt <= w_cnt_load;
        else if (r_state == c_WAIT && r_cnt != 0) r_cnt <= r_cnt - 5'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel_d  <= 1'b0;
            r_hi     <= 1'b0;
            r_inr    <= 1'b0;
            r_idx    <= '0;
            r_strobe <= 8'h00;
            r_wdata  <= 64'd0;
        end else if (w_accept) begin
            r_sel_d  <= dreq_valid;
            r_hi     <= w_addr[2];
            r_inr    <= w_in_range;
            r_idx    <= w_off[c_IDX_W+2:3];
            r_strobe <= dreq_valid ? dreq_strobe : 8'h00;
            r_wdata  <= dreq_data;
        end
    end

    assign w_word = r_inr ? r_mem[r_idx] : 64'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_iaddr_ok <= 1'b0;
            r_idata_ok <= 1'b0;
            r_irdata   <= 32'd0;
            r_daddr_ok <= 1'b0;
            r_ddata_ok <= 1'b0;
            r_drdata   <= 64'd0;
        end else begin
            r_daddr_ok <= w_accept_d;
            r_iaddr_ok <= w_accept && !dreq_valid;
            r_ddata_ok <= w_fire && r_sel_d;
            r_idata_ok <= w_fire && !r_sel_d;
            if (w_fire) begin
                if (r_sel_d) r_drdata <= w_word;
                else         r_irdata <= r_hi ? w_word[63:32] : w_word[31:0];
            end
        end
    end

    // Contents are deliberately not reset; rst gating keeps an aborted store from landing.
    always_ff @(posedge clk) begin
        if (w_fire && r_inr && !rst) begin
            for (int i = 0; i < 8; i++) begin
                if (r_strobe[i]) r_mem[r_idx][8*i +: 8] <= r_wdata[8*i +: 8];
            end
        end
    end

    assign iresp_addr_ok = r_iaddr_ok;
    assign iresp_data_ok = r_idata_ok;
    assign iresp_data    = r_irdata;
    assign dresp_addr_ok = r_daddr_ok;
    assign dresp_data_ok = r_ddata_ok;
    assign dresp_data    = r_drdata;

endmodule

`default_nettype wire

// File: tb/tb_bus_mem_responder.sv
// ============================================================================
// Module      : tb_bus_mem_responder
// Description : Randomized self-checking bench for bus_mem_responder against
//               a word-array reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bus_mem_responder;

    localparam int          LAT  = 2;
    localparam int          MEMW = 8192;
    localparam logic [63:0] BASE = 64'h8000_0000;
`ifdef BUS_RESP_RANDOM_DELAY_EN
    localparam int          XTRA = 3;
`else
    localparam int          XTRA = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ireq_valid = 1'b0;
    logic [63:0] ireq_addr = 64'd0;
    logic        iresp_addr_ok;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;
    logic        dreq_valid = 1'b0;
    logic [63:0] dreq_addr = 64'd0;
    logic [2:0]  dreq_size = 3'd3;
    logic [7:0]  dreq_strobe = 8'h00;
    logic [63:0] dreq_data = 64'd0;
    logic        dresp_addr_ok;
    logic        dresp_data_ok;
    logic [63:0] dresp_data;

    int n_vec = 0;
    int n_err = 0;
    logic [63:0] mdl [longint unsigned];

    bus_mem_responder #(.MEM_WORDS(MEMW), .BASE_ADDR(BASE), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
        .iresp_addr_ok(iresp_addr_ok), .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
        .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
        .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
        .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data)
    );

    always #5 clk = ~clk;

    function automatic bit mdl_inr(input logic [63:0] a);
        return (a >= BASE) && ((a - BASE) < 64'(8 * MEMW));
    endfunction

    function automatic longint unsigned widx(input logic [63:0] a);
        return longint'((a - BASE) / 8);
    endfunction

    function automatic logic [63:0] mdl_read(input logic [63:0] a);
        if (!mdl_inr(a) || !mdl.exists(widx(a))) return 64'd0;
        return mdl[widx(a)];
    endfunction

    task automatic mdl_write(input logic [63:0] a, input logic [7:0] s, input logic [63:0] wd);
        logic [63:0] w;
        if (!mdl_inr(a)) return;
        w = mdl_read(a);
        for (int i = 0; i < 8; i++) if (s[i]) w[8*i +: 8] = wd[8*i +: 8];
        mdl[widx(a)] = w;
    endtask

    // Drives one dbus transaction; reports cycles to addr_ok, cycles to data_ok, protocol flag.
    task automatic dbus_txn(input logic [63:0] a, input logic [7:0] s, input logic [63:0] wd,
                            output logic [63:0] rd, output int acyc, output int lat, output bit bad);
        bad = 1'b0; acyc = 0; lat = 0; rd = 64'd0;
        dreq_valid = 1'b1; dreq_addr = a; dreq_strobe = s; dreq_data = wd;
        dreq_size = (s == 8'h00) ? 3'd3 : 3'd2;
        do begin
            @(posedge clk); #1; acyc++;
            if (dresp_data_ok || iresp_addr_ok || iresp_data_ok) bad = 1'b1;
        end while (!dresp_addr_ok && acyc < 50);
        if (!dresp_addr_ok) bad = 1'b1;
        do begin
            @(posedge clk); #1; lat++;
            if (dresp_addr_ok || iresp_addr_ok || iresp_data_ok) bad = 1'b1;
        end while (!dresp_data_ok && lat < 50);
        if (!dresp_data_ok) bad = 1'b1;
        rd = dresp_data;
        dreq_valid = 1'b0; dreq_strobe = 8'h00;
    endtask

    task automatic ibus_txn(input logic [63:0] a, output logic [31:0] rd,
                            output int acyc, output int lat, output bit bad);
        bad = 1'b0; acyc = 0; lat = 0; rd = 32'd0;
        ireq_valid = 1'b1; ireq_addr = a;
        do begin
            @(posedge clk); #1; acyc++;
            if (iresp_data_ok || dresp_addr_ok || dresp_data_ok) bad = 1'b1;
        end while (!iresp_addr_ok && acyc < 50);
        if (!iresp_addr_ok) bad = 1'b1;
        do begin
            @(posedge clk); #1; lat++;
            if (iresp_addr_ok || dresp_addr_ok || dresp_data_ok) bad = 1'b1;
        end while (!iresp_data_ok && lat < 50);
        if (!iresp_data_ok) bad = 1'b1;
        rd = iresp_data;
        ireq_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if ({iresp_addr_ok, iresp_data_ok, dresp_addr_ok, dresp_data_ok} !== 4'b0000) begin
            n_err++; $display("FAIL reset_handshakes: got %b want 0000", {iresp_addr_ok, iresp_data_ok, dresp_addr_ok, dresp_data_ok});
        end
        n_vec++; if (iresp_data !== 32'd0) begin
            n_err++; $display("FAIL reset_idata: got %h want 0", iresp_data);
        end
        n_vec++; if (dresp_data !== 64'd0) begin
            n_err++; $display("FAIL reset_ddata: got %h want 0", dresp_data);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_fetch();
        logic [63:0] rd; logic [31:0] ird; int ac, lat; bit bad;
        dbus_txn(BASE, 8'hFF, 64'h1122_3344_5566_7788, rd, ac, lat, bad);
        mdl_write(BASE, 8'hFF, 64'h1122_3344_5566_7788);
        @(posedge clk); #1;
        ibus_txn(BASE + 64'd4, ird, ac, lat, bad);
        n_vec++; if (bad || ac != 1) begin
            n_err++; $display("FAIL fetch_addr_ok: got %0d cycles bad=%0d want 1", ac, bad);
        end
        n_vec++; if (lat != LAT && XTRA == 0) begin
            n_err++; $display("FAIL fetch_latency: got %0d want %0d", lat, LAT);
        end
        n_vec++; if (ird !== 32'h1122_3344) begin
            n_err++; $display("FAIL fetch_hi: got %h want 11223344", ird);
        end
        ibus_txn(BASE, ird, ac, lat, bad);
        n_vec++; if (ird !== 32'h5566_7788 || bad) begin
            n_err++; $display("FAIL fetch_lo: got %h want 55667788", ird);
        end
    endtask

    task automatic test_store_load();
        logic [63:0] rd; int ac, lat; bit bad;
        dbus_txn(BASE + 64'd8, 8'hFF, 64'd0, rd, ac, lat, bad);
        mdl_write(BASE + 64'd8, 8'hFF, 64'd0);
        dbus_txn(BASE + 64'd8, 8'h0F, 64'hAAAA_BBBB_CCCC_DDDD, rd, ac, lat, bad);
        mdl_write(BASE + 64'd8, 8'h0F, 64'hAAAA_BBBB_CCCC_DDDD);
        n_vec++; if (rd !== 64'd0 || bad) begin
            n_err++; $display("FAIL store_prewrite: got %h bad=%0d want 0", rd, bad);
        end
        dbus_txn(BASE + 64'd8, 8'h00, 64'd0, rd, ac, lat, bad);
        n_vec++; if (rd !== 64'h0000_0000_CCCC_DDDD || bad) begin
            n_err++; $display("FAIL partial_store_load: got %h want 00000000ccccdddd", rd);
        end
    endtask

    task automatic test_priority();
        int cyc = 0, da = -1, dd = -1, ia = -1, id = -1;
        logic [63:0] drd = 64'd0; logic [31:0] ird = 32'd0; logic [63:0] w3;
        w3 = mdl_read(BASE + 64'd24);
        @(posedge clk); #1;
        dreq_valid = 1'b1; dreq_addr = BASE + 64'd8; dreq_strobe = 8'h00;
        ireq_valid = 1'b1; ireq_addr = BASE + 64'd28;
        while (id < 0 && cyc < 100) begin
            @(posedge clk); #1; cyc++;
            if (dresp_addr_ok && da < 0) da = cyc;
            if (iresp_addr_ok && ia < 0) ia = cyc;
            if (dresp_data_ok && dd < 0) begin dd = cyc; drd = dresp_data; dreq_valid = 1'b0; end
            if (iresp_data_ok) begin id = cyc; ird = iresp_data; ireq_valid = 1'b0; end
        end
        ireq_valid = 1'b0; dreq_valid = 1'b0;
        n_vec++; if (da != 1) begin
            n_err++; $display("FAIL prio_dbus_first: got dresp_addr_ok at %0d want 1", da);
        end
        n_vec++; if (dd < 0 || ia <= dd) begin
            n_err++; $display("FAIL prio_ibus_after: got iaddr_ok %0d ddata_ok %0d want iaddr_ok later", ia, dd);
        end
        n_vec++; if (drd !== mdl_read(BASE + 64'd8)) begin
            n_err++; $display("FAIL prio_ddata: got %h want %h", drd, mdl_read(BASE + 64'd8));
        end
        n_vec++; if (id < 0 || ird !== w3[63:32]) begin
            n_err++; $display("FAIL prio_idata: got %h want %h", ird, w3[63:32]);
        end
    endtask

    task automatic test_random();
        logic [63:0] a, wd, old, rd; logic [31:0] ird; logic [7:0] s;
        int ac, lat, kind; bit bad;
        for (int i = 2; i < 16; i++) begin
            wd = {$urandom, $urandom};
            dbus_txn(BASE + 64'(i * 8), 8'hFF, wd, rd, ac, lat, bad);
            mdl_write(BASE + 64'(i * 8), 8'hFF, wd);
        end
        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 2);
            a = BASE + 64'($urandom_range(0, 15) * 8 + $urandom_range(0, 7));
            if ($urandom_range(0, 5) == 0)
                a = ($urandom_range(0, 1) == 1) ? BASE + 64'(8 * MEMW) + 64'($urandom_range(0, 1023) * 8)
                                                 : BASE - 64'd8 - 64'($urandom_range(0, 1023) * 8);
            old = mdl_read(a);
            if (kind == 2) begin
                a[1:0] = 2'b00;
                ibus_txn(a, ird, ac, lat, bad);
                n_vec++; if (ird !== (a[2] ? old[63:32] : old[31:0])) begin
                    n_err++; $display("FAIL rand_fetch %h: got %h want %h", a, ird, a[2] ? old[63:32] : old[31:0]);
                end
            end else begin
                s = (kind == 1) ? 8'($urandom_range(1, 255)) : 8'h00;
                wd = {$urandom, $urandom};
                dbus_txn(a, s, wd, rd, ac, lat, bad);
                mdl_write(a, s, wd);
                n_vec++; if (rd !== old) begin
                    n_err++; $display("FAIL rand_dbus %h strb %h: got %h want %h", a, s, rd, old);
                end
            end
            n_vec++; if (bad || lat < LAT || lat > LAT + XTRA) begin
                n_err++; $display("FAIL rand_handshake %0d: latency %0d bad=%0d want %0d..%0d", n, lat, bad, LAT, LAT + XTRA);
            end
        end
    endtask

    task automatic test_out_of_range();
        logic [63:0] rd; int ac, lat; bit bad;
        dbus_txn(64'h7FFF_FFF8, 8'h00, 64'd0, rd, ac, lat, bad);
        n_vec++; if (rd !== 64'd0 || bad) begin
            n_err++; $display("FAIL oor_load: got %h bad=%0d want 0", rd, bad);
        end
        dbus_txn(BASE + 64'(8 * MEMW), 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF, rd, ac, lat, bad);
        n_vec++; if (rd !== 64'd0 || bad) begin
            n_err++; $display("FAIL oor_store: got %h bad=%0d want 0", rd, bad);
        end
        dbus_txn(BASE, 8'h00, 64'd0, rd, ac, lat, bad);
        n_vec++; if (rd !== mdl_read(BASE)) begin
            n_err++; $display("FAIL oor_no_alias: got %h want %h", rd, mdl_read(BASE));
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] rd, old; int ac, lat, cyc, seen; bit bad;
        old = mdl_read(BASE + 64'd40);
        @(posedge clk); #1;
        dreq_valid = 1'b1; dreq_addr = BASE + 64'd40; dreq_strobe = 8'hFF; dreq_data = ~old;
        cyc = 0;
        do begin @(posedge clk); #1; cyc++; end while (!dresp_addr_ok && cyc < 50);
        #2; rst = 1'b1; dreq_valid = 1'b0; dreq_strobe = 8'h00;
        @(posedge clk); #1; rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (dresp_data_ok || iresp_data_ok) seen++;
        end
        n_vec++; if (seen != 0 || cyc >= 50) begin
            n_err++; $display("FAIL rstmid_no_data_ok: got %0d pulses want 0", seen);
        end
        dbus_txn(BASE + 64'd40, 8'h00, 64'd0, rd, ac, lat, bad);
        n_vec++; if (rd !== old) begin
            n_err++; $display("FAIL rstmid_store_dropped: got %h want %h", rd, old);
        end
        n_vec++; if (bad || ac != 1) begin
            n_err++; $display("FAIL rstmid_next_accept: got %0d cycles bad=%0d want 1", ac, bad);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] a, w; logic [31:0] ird; int ac, lat; bit bad;
        for (int n = 0; n < 100; n++) begin
            a = BASE + 64'($urandom_range(0, 15) * 8 + $urandom_range(0, 1) * 4);
            w = mdl_read(a);
            ibus_txn(a, ird, ac, lat, bad);
            n_vec++; if (bad || ac < 1 || ac > 2) begin
                n_err++; $display("FAIL b2b_handshake %0d: addr_ok after %0d bad=%0d", n, ac, bad);
            end
            n_vec++; if (lat < LAT || lat > LAT + XTRA) begin
                n_err++; $display("FAIL b2b_latency %0d: got %0d want %0d..%0d", n, lat, LAT, LAT + XTRA);
            end
            n_vec++; if (ird !== (a[2] ? w[63:32] : w[31:0])) begin
                n_err++; $display("FAIL b2b_data %0d: got %h want %h", n, ird, a[2] ? w[63:32] : w[31:0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store_load();
        test_priority();
        test_random();
        test_out_of_range();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
